// File: rtl/core_pkg.sv
// Shared types for the RV32I bus sequencer: FSM states, opcode values and op classes.
// Consumed by bus_sequencer and opcode_classifier via import core_pkg::*.
package core_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5,
    TRAP      = 3'd6
  } state_t;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_OP      = 4'd0,
    CLS_OP_IMM  = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_SYSTEM  = 4'd9,
    CLS_ILLEGAL = 4'd10
  } op_class_t;

  // ALU operand B takes the immediate for these classes.
  function automatic logic uses_imm(input op_class_t c);
    return (c == CLS_OP_IMM) || (c == CLS_LOAD) || (c == CLS_STORE) ||
           (c == CLS_JALR) || (c == CLS_AUIPC) || (c == CLS_JAL);
  endfunction

  // ALU operand A takes the PC for these classes.
  function automatic logic uses_pc(input op_class_t c);
    return (c == CLS_AUIPC) || (c == CLS_JAL) || (c == CLS_BRANCH);
  endfunction

endpackage

// File: rtl/bus_sequencer_opcode_classifier.sv
// Combinational lookup from the 7-bit RV32I major opcode to its op class.
// Any encoding outside the supported set maps to CLS_ILLEGAL.
module opcode_classifier
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [3:0] op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OPCODE_OP:     op_class = CLS_OP;
      OPCODE_OP_IMM: op_class = CLS_OP_IMM;
      OPCODE_LOAD:   op_class = CLS_LOAD;
      OPCODE_STORE:  op_class = CLS_STORE;
      OPCODE_BRANCH: op_class = CLS_BRANCH;
      OPCODE_JAL:    op_class = CLS_JAL;
      OPCODE_JALR:   op_class = CLS_JALR;
      OPCODE_LUI:    op_class = CLS_LUI;
      OPCODE_AUIPC:  op_class = CLS_AUIPC;
      OPCODE_SYSTEM: op_class = CLS_SYSTEM;
      default:       op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/bus_sequencer.sv
// Multi-cycle control FSM feeding the main data bus mux of the RV32I core.
// Optional memory-wait timeout to TRAP is compiled in with `define MEM_TIMEOUT_EN.
//
// state     | meaning
// FETCH     | idle when run=0, else read instruction at PC until mem_ready
// DECODE    | register op class; route to EXECUTE, HALT or TRAP
// EXECUTE   | drive ALU operand selects; branches resolve and retire here
// MEM       | load/store data access at ALU address until mem_ready
// WRITEBACK | write ALU/decoder value into rd, update PC, retire
// HALT      | SYSTEM opcode reached, wait for rst
// TRAP      | illegal opcode or memory timeout, wait for rst
module bus_sequencer
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int INSTRET_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [6:0]               opcode,
  input  logic                     branch_taken,
  input  logic                     mem_ready,
  output logic                     sel_alu,
  output logic                     sel_register_bank,
  output logic                     sel_decoder,
  output logic                     sel_memory,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic                     addr_sel_pc,
  output logic                     alu_a_pc,
  output logic                     alu_b_imm,
  output logic                     ir_load,
  output logic                     reg_write,
  output logic                     pc_inc,
  output logic                     pc_load,
  output logic                     halted,
  output logic                     trap,
  output logic [INSTRET_WIDTH-1:0] instret
);

  state_t    state;
  state_t    state_n;
  op_class_t cls_q;
  op_class_t cls_d;
  logic [3:0] cls_raw;
  logic      retire;
  logic      timeout;

  opcode_classifier u_classifier (
    .opcode   (opcode),
    .op_class (cls_raw)
  );

  assign cls_d = op_class_t'(cls_raw);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      cls_q   <= CLS_ILLEGAL;
      instret <= '0;
    end else begin
      state <= state_n;
      if (state == DECODE) begin
        cls_q <= cls_d;
      end
      if (retire) begin
        instret <= instret + 1'b1;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_left;
  logic              waiting;

  // Derived from state rather than mem_req to keep the loop through the FSM comb block open.
  assign waiting = (((state == FETCH) && run) || (state == MEM)) && !mem_ready;
  assign timeout = waiting && (wait_left == WAIT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_left <= WAIT_W'(TIMEOUT_CYCLES);
    end else if (state_n != state) begin
      wait_left <= WAIT_W'(TIMEOUT_CYCLES);
    end else if (waiting && (wait_left != '0)) begin
      wait_left <= wait_left - 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n           = state;
    retire            = 1'b0;
    sel_alu           = 1'b0;
    sel_register_bank = 1'b0;
    sel_decoder       = 1'b0;
    sel_memory        = 1'b0;
    mem_req           = 1'b0;
    mem_we            = 1'b0;
    addr_sel_pc       = 1'b0;
    alu_a_pc          = 1'b0;
    alu_b_imm         = 1'b0;
    ir_load           = 1'b0;
    reg_write         = 1'b0;
    pc_inc            = 1'b0;
    pc_load           = 1'b0;
    halted            = 1'b0;
    trap              = 1'b0;

    case (state)
      FETCH: begin
        if (run) begin
          mem_req     = 1'b1;
          addr_sel_pc = 1'b1;
          sel_memory  = 1'b1;
          if (mem_ready) begin
            ir_load = 1'b1;
            state_n = DECODE;
          end else if (timeout) begin
            state_n = TRAP;
          end
        end
      end

      DECODE: begin
        if (cls_d == CLS_ILLEGAL) begin
          state_n = TRAP;
        end else if (cls_d == CLS_SYSTEM) begin
          state_n = HALT;
        end else begin
          state_n = EXECUTE;
        end
      end

      EXECUTE: begin
        alu_b_imm = uses_imm(cls_q);
        alu_a_pc  = uses_pc(cls_q);
        if (cls_q == CLS_BRANCH) begin
          pc_load = branch_taken;
          pc_inc  = !branch_taken;
          retire  = 1'b1;
          state_n = FETCH;
        end else if ((cls_q == CLS_LOAD) || (cls_q == CLS_STORE)) begin
          state_n = MEM;
        end else begin
          state_n = WRITEBACK;
        end
      end

      MEM: begin
        mem_req = 1'b1;
        if (cls_q == CLS_STORE) begin
          mem_we            = 1'b1;
          sel_register_bank = 1'b1;
        end else begin
          sel_memory = 1'b1;
        end
        if (mem_ready) begin
          reg_write = (cls_q == CLS_LOAD);
          pc_inc    = 1'b1;
          retire    = 1'b1;
          state_n   = FETCH;
        end else if (timeout) begin
          state_n = TRAP;
        end
      end

      WRITEBACK: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_n   = FETCH;
        case (cls_q)
          CLS_LUI: begin
            sel_decoder = 1'b1;
            pc_inc      = 1'b1;
          end
          CLS_JAL, CLS_JALR: begin
            sel_decoder = 1'b1;
            pc_load     = 1'b1;
          end
          default: begin
            sel_alu = 1'b1;
            pc_inc  = 1'b1;
          end
        endcase
      end

      HALT: halted = 1'b1;

      TRAP: trap = 1'b1;

      default: state_n = FETCH;
    endcase

    // A reset cycle aborts whatever is in flight: nothing is requested, written or retired.
    if (rst) begin
      state_n           = FETCH;
      retire            = 1'b0;
      sel_alu           = 1'b0;
      sel_register_bank = 1'b0;
      sel_decoder       = 1'b0;
      sel_memory        = 1'b0;
      mem_req           = 1'b0;
      mem_we            = 1'b0;
      addr_sel_pc       = 1'b0;
      alu_a_pc          = 1'b0;
      alu_b_imm         = 1'b0;
      ir_load           = 1'b0;
      reg_write         = 1'b0;
      pc_inc            = 1'b0;
      pc_load           = 1'b0;
      halted            = 1'b0;
      trap              = 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: opcode table, randomized instruction stream
// against a per-instruction cycle model, and hand sequences for reset, trap, halt and waits.
module tb_bus_sequencer;

`ifdef MEM_TIMEOUT_EN
  localparam int TO_CYC = 4;
  localparam int MAXW   = 3;
`else
  localparam int TO_CYC = 255;
  localparam int MAXW   = 5;
`endif

  localparam logic [6:0] K_OP     = 7'b0110011;
  localparam logic [6:0] K_OP_IMM = 7'b0010011;
  localparam logic [6:0] K_LOAD   = 7'b0000011;
  localparam logic [6:0] K_STORE  = 7'b0100011;
  localparam logic [6:0] K_BRANCH = 7'b1100011;
  localparam logic [6:0] K_JAL    = 7'b1101111;
  localparam logic [6:0] K_JALR   = 7'b1100111;
  localparam logic [6:0] K_LUI    = 7'b0110111;
  localparam logic [6:0] K_AUIPC  = 7'b0010111;
  localparam logic [6:0] K_SYSTEM = 7'b1110011;

  logic clk = 1'b0;
  logic rst, run, branch_taken, mem_ready;
  logic [6:0] opcode;
  logic sel_alu, sel_register_bank, sel_decoder, sel_memory, mem_req, mem_we, addr_sel_pc;
  logic alu_a_pc, alu_b_imm, ir_load, reg_write, pc_inc, pc_load, halted, trap;
  logic [31:0] instret;

  always #5 clk = ~clk;

  bus_sequencer #(.TIMEOUT_CYCLES(TO_CYC), .INSTRET_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .sel_alu(sel_alu), .sel_register_bank(sel_register_bank),
    .sel_decoder(sel_decoder), .sel_memory(sel_memory), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel_pc(addr_sel_pc), .alu_a_pc(alu_a_pc), .alu_b_imm(alu_b_imm), .ir_load(ir_load),
    .reg_write(reg_write), .pc_inc(pc_inc), .pc_load(pc_load), .halted(halted), .trap(trap),
    .instret(instret)
  );

  typedef struct packed {
    logic sel_alu, sel_rb, sel_dec, sel_mem, mem_req, mem_we, addr_pc, a_pc, b_imm;
    logic ir_load, reg_write, pc_inc, pc_load, halted, trap;
  } outs_t;

  typedef struct {
    logic        run, mr, bt;
    logic [6:0]  op;
    outs_t       exp;
    logic [31:0] inst;
  } step_t;

  typedef struct {
    logic [6:0] op;
    logic       bt;
    int         cycles;
    logic [3:0] sels;   // {alu, rb, dec, mem} seen outside fetch
    int         n_rw, n_inc, n_load;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  step_t q[$];
  logic [31:0] model_instret = 0;

  function automatic outs_t get_outs();
    outs_t o;
    o.sel_alu = sel_alu;   o.sel_rb = sel_register_bank; o.sel_dec = sel_decoder;
    o.sel_mem = sel_memory; o.mem_req = mem_req; o.mem_we = mem_we; o.addr_pc = addr_sel_pc;
    o.a_pc = alu_a_pc; o.b_imm = alu_b_imm; o.ir_load = ir_load; o.reg_write = reg_write;
    o.pc_inc = pc_inc; o.pc_load = pc_load; o.halted = halted; o.trap = trap;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Invariants sampled mid-cycle on every clock.
  always @(negedge clk) begin
    #2;
    n_checks++;
    if (!$onehot0({sel_alu, sel_register_bank, sel_decoder, sel_memory}) || (pc_inc && pc_load)) begin
      n_fail++;
      $display("FAIL invariant: sel=%b pc_inc=%b pc_load=%b required onehot0 sel, not both pc",
               {sel_alu, sel_register_bank, sel_decoder, sel_memory}, pc_inc, pc_load);
    end
  end

  function automatic logic [6:0] rnd_op();
    return 7'($urandom);
  endfunction

  task automatic push(input logic r, input logic mr, input logic bt, input logic [6:0] op,
                      input outs_t o);
    step_t s;
    s.run = r; s.mr = mr; s.bt = bt; s.op = op; s.exp = o; s.inst = model_instret;
    q.push_back(s);
  endtask

  function automatic outs_t fetch_outs(input logic done);
    outs_t o = '0;
    o.mem_req = 1'b1; o.addr_pc = 1'b1; o.sel_mem = 1'b1; o.ir_load = done;
    return o;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, built from the opcode rules.
  task automatic add_instr(input logic [6:0] op, input int wf, input int wm, input logic bt);
    outs_t o;
    logic ld, st, br;
    ld = (op == K_LOAD); st = (op == K_STORE); br = (op == K_BRANCH);
    for (int i = 0; i <= wf; i++) push(1'b1, i == wf, 1'($urandom), rnd_op(), fetch_outs(i == wf));
    push(1'b1, 1'($urandom), 1'($urandom), op, '0);
    o = '0;
    o.b_imm = (op == K_OP_IMM) || ld || st || (op == K_JALR) || (op == K_AUIPC) || (op == K_JAL);
    o.a_pc  = (op == K_AUIPC) || (op == K_JAL) || br;
    if (br) begin
      o.pc_load = bt; o.pc_inc = !bt;
      push(1'b1, 1'($urandom), bt, rnd_op(), o);
      model_instret++;
      return;
    end
    push(1'b1, 1'($urandom), 1'($urandom), rnd_op(), o);
    if (ld || st) begin
      for (int i = 0; i <= wm; i++) begin
        o = '0;
        o.mem_req = 1'b1; o.mem_we = st; o.sel_rb = st; o.sel_mem = ld;
        o.pc_inc = (i == wm); o.reg_write = ld && (i == wm);
        push(1'b1, i == wm, 1'($urandom), rnd_op(), o);
      end
    end else begin
      o = '0;
      o.reg_write = 1'b1;
      if (op == K_JAL || op == K_JALR) begin o.sel_dec = 1'b1; o.pc_load = 1'b1; end
      else if (op == K_LUI) begin o.sel_dec = 1'b1; o.pc_inc = 1'b1; end
      else begin o.sel_alu = 1'b1; o.pc_inc = 1'b1; end
      push(1'b1, 1'($urandom), 1'($urandom), rnd_op(), o);
    end
    model_instret++;
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'($urandom), 1'($urandom), rnd_op(), '0);
  endtask

  // Illegal or SYSTEM opcode: fetch, decode, then n cycles parked in TRAP/HALT.
  task automatic add_stop(input logic [6:0] op, input int wf, input int n, input logic is_halt);
    outs_t o = '0;
    for (int i = 0; i <= wf; i++) push(1'b1, i == wf, 1'($urandom), rnd_op(), fetch_outs(i == wf));
    push(1'b1, 1'($urandom), 1'($urandom), op, '0);
    o.halted = is_halt; o.trap = !is_halt;
    for (int i = 0; i < n; i++) push(1'($urandom), 1'($urandom), 1'($urandom), rnd_op(), o);
  endtask

  task automatic run_queue(input string name);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      run = s.run; mem_ready = s.mr; branch_taken = s.bt; opcode = s.op;
      #1;
      check({name, " outs"}, 32'(get_outs()), 32'(s.exp));
      check({name, " instret"}, instret, s.inst);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'($urandom); mem_ready = 1'($urandom); opcode = rnd_op();
    #1 check("reset outs", 32'(get_outs()), 32'd0);
    @(posedge clk);
    #1 check("reset outs after edge", 32'(get_outs()), 32'd0);
    check("reset instret", instret, 32'd0);
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    #1 check("post-reset idle outs", 32'(get_outs()), 32'd0);
    model_instret = 0;
  endtask

  vec_t vec[10];
  logic [6:0] legal[9];

  initial begin
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; opcode = '0;
    do_reset();

    // Zero-wait latency and pulse table.
    vec[0] = '{K_OP,     1'b0, 4, 4'b1000, 1, 1, 0};
    vec[1] = '{K_OP_IMM, 1'b0, 4, 4'b1000, 1, 1, 0};
    vec[2] = '{K_AUIPC,  1'b0, 4, 4'b1000, 1, 1, 0};
    vec[3] = '{K_LUI,    1'b0, 4, 4'b0010, 1, 1, 0};
    vec[4] = '{K_JAL,    1'b0, 4, 4'b0010, 1, 0, 1};
    vec[5] = '{K_JALR,   1'b0, 4, 4'b0010, 1, 0, 1};
    vec[6] = '{K_BRANCH, 1'b1, 3, 4'b0000, 0, 0, 1};
    vec[7] = '{K_BRANCH, 1'b0, 3, 4'b0000, 0, 1, 0};
    vec[8] = '{K_LOAD,   1'b0, 4, 4'b0001, 1, 1, 0};
    vec[9] = '{K_STORE,  1'b0, 4, 4'b0100, 0, 1, 0};
    for (int v = 0; v < 10; v++) begin
      int cyc, nrw, ninc, nld;
      logic [3:0] sels;
      logic [31:0] start;
      cyc = 0; nrw = 0; ninc = 0; nld = 0; sels = '0;
      start = instret;
      while (cyc < 12) begin
        @(negedge clk);
        run = 1'b1; mem_ready = 1'b1; opcode = vec[v].op; branch_taken = vec[v].bt;
        #1;
        cyc++;
        nrw += int'(reg_write); ninc += int'(pc_inc); nld += int'(pc_load);
        if (!addr_sel_pc) sels |= {sel_alu, sel_register_bank, sel_decoder, sel_memory};
        @(posedge clk);
        #1;
        if (instret != start) break;
      end
      check($sformatf("tbl%0d cycles", v), cyc, vec[v].cycles);
      check($sformatf("tbl%0d sels", v), 32'(sels), 32'(vec[v].sels));
      check($sformatf("tbl%0d reg_write", v), nrw, vec[v].n_rw);
      check($sformatf("tbl%0d pc_inc", v), ninc, vec[v].n_inc);
      check($sformatf("tbl%0d pc_load", v), nld, vec[v].n_load);
      check($sformatf("tbl%0d instret", v), instret, start + 32'd1);
      model_instret = instret;
    end
    @(negedge clk); run = 1'b0;
    model_instret = start_sync();

    // Randomized instruction stream.
    legal = '{K_OP, K_OP_IMM, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR, K_LUI, K_AUIPC};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) add_idle($urandom_range(1, 3));
      add_instr(legal[$urandom_range(0, 8)], $urandom_range(0, MAXW), $urandom_range(0, MAXW),
                1'($urandom));
      run_queue("rand");
    end

    // Directed: LOAD with three wait cycles, STORE, taken/not-taken BRANCH.
    add_instr(K_LOAD, 0, 3, 1'b0);
    add_instr(K_STORE, 1, 2, 1'b0);
    add_instr(K_BRANCH, 0, 0, 1'b1);
    add_instr(K_BRANCH, 0, 0, 1'b0);
    run_queue("directed");

    // Illegal opcodes trap, SYSTEM halts; only rst leaves them.
    add_stop(7'b0000000, 1, 5, 1'b0);
    run_queue("trap");
    do_reset();
    add_instr(K_OP, 0, 0, 1'b0);
    add_stop(7'b1111111, 0, 3, 1'b0);
    run_queue("trap2");
    do_reset();
    add_stop(K_SYSTEM, 2, 5, 1'b1);
    run_queue("halt");
    do_reset();

    // Reset during a MEM wait aborts the load even if memory answers that cycle.
    add_instr(K_OP, 0, 0, 1'b0);
    run_queue("pre-abort");
    add_instr(K_LOAD, 0, 10, 1'b0);
    q = q[0:5];
    run_queue("abort setup");
    @(negedge clk);
    rst = 1'b1; run = 1'b1; mem_ready = 1'b1; opcode = K_LOAD;
    #1 check("abort mem_req", 32'(mem_req), 32'd0);
    check("abort reg_write", 32'(reg_write), 32'd0);
    check("abort pc_inc", 32'(pc_inc), 32'd0);
    @(posedge clk);
    #1 check("abort outs after edge", 32'(get_outs()), 32'd0);
    check("abort instret", instret, 32'd0);
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    #1 check("abort idle", 32'(get_outs()), 32'd0);
    model_instret = 0;
    add_instr(K_OP, 0, 0, 1'b0);
    run_queue("after abort");

`ifdef MEM_TIMEOUT_EN
    begin
      outs_t tr;
      tr = '0; tr.trap = 1'b1;
      for (int i = 0; i < TO_CYC; i++) push(1'b1, 1'b0, 1'($urandom), rnd_op(), fetch_outs(1'b0));
      for (int i = 0; i < 3; i++) push(1'b1, 1'($urandom), 1'($urandom), rnd_op(), tr);
      run_queue("fetch timeout");
      do_reset();
      add_instr(K_LOAD, 0, 10, 1'b0);
      q = q[0:2 + TO_CYC];
      model_instret = 0;
      for (int i = 0; i < 2; i++) push(1'b1, 1'($urandom), 1'($urandom), rnd_op(), tr);
      run_queue("mem timeout");
      do_reset();
    end
`else
    // No timeout hardware: a 1000-cycle fetch stall keeps waiting, then completes normally.
    add_instr(K_OP, 1000, 0, 1'b0);
    run_queue("long wait");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [31:0] start_sync();
    return model_instret;
  endfunction

endmodule
